fifo_rr_drain: RTL
==================

FIFO_RR_DRAIN -- requirements
Module: fifo_rr_drain

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requester FIFO read ports (2..8).
REQ-002 SHALL have parameter BURST, default 8, words per granted burst (2..256).
REQ-003 SHALL have port rd_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  permits new grants; a burst already in progress always completes.
REQ-006 SHALL have port fifo_empty  input  NREQ  per-FIFO empty flag (FWFT read side).
REQ-007 SHALL have port fifo_dout  input  NREQ*32  per-FIFO FWFT data; requester i occupies bits [32*i+31:32*i].
REQ-008 SHALL have port fifo_rd_en  output  NREQ  per-FIFO read enable (pop).
REQ-009 SHALL have port out_data  output  32  drained word.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port out_src  output  clog2(NREQ)  index of the granted requester.
REQ-013 SHALL have port out_last  output  1  marks the final word of a burst.
REQ-014 SHALL have port busy  output  1  high while in XFER.

Function
REQ-015 SHALL implement the FSM states IDLE and XFER.
REQ-016 In IDLE with en=1 and any fifo_empty[i]=0, SHALL register gnt = first non-empty index searching ptr, ptr+1, ... modulo NREQ, and go to XFER next cycle.
REQ-017 In IDLE, SHALL assert no fifo_rd_en and hold out_valid=0.
REQ-018 In XFER, out_valid SHALL equal ~fifo_empty[gnt] combinationally, out_data SHALL equal fifo_dout[gnt], and out_src SHALL equal gnt.
REQ-019 In XFER, fifo_rd_en[gnt] SHALL equal out_valid & out_ready; all other fifo_rd_en bits SHALL be 0.
REQ-020 A transfer SHALL occur on a cycle with out_valid & out_ready; the word counter cnt (0..BURST-1) SHALL increment only on a transfer.
REQ-021 out_last SHALL equal out_valid & (cnt==BURST-1).
REQ-022 On the transfer with cnt==BURST-1, SHALL clear cnt, set ptr=(gnt+1) mod NREQ, and return to IDLE.
REQ-023 If the granted FIFO empties mid-burst, SHALL stay in XFER with out_valid=0 and never switch requester until BURST words are transferred.
REQ-024 If out_ready=0, SHALL hold out_data/out_src stable and pop nothing.
REQ-025 Deasserting en mid-burst SHALL NOT abort the burst; the FSM SHALL stay in IDLE afterwards while en=0.
REQ-026 Changes of fifo_empty on non-granted requesters SHALL NOT affect the current burst.
REQ-027 Minimum spacing SHALL be one IDLE cycle between bursts; peak throughput is BURST words per BURST+1 cycles.
REQ-028 The arbiter SHALL be starvation-free: a requester that stays non-empty SHALL be granted within NREQ-1 bursts of others.

Reset
REQ-029 On a cycle with rst=1, SHALL set state=IDLE, ptr=0, gnt=0, and cnt=0.
REQ-030 During and after reset, fifo_rd_en SHALL be all 0, and out_valid, out_last, and busy SHALL be 0.
REQ-031 out_data and out_src SHALL be don't-care while out_valid=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst; the words already popped are not replayed, and the next grant starts from requester 0.

Verification
REQ-033 NREQ=4, BURST=8, all FIFOs loaded with 16 words, out_ready=1 -> bursts granted in the order 0,1,2,3,0,...; each burst is 8 words with out_last on the 8th, and there is one idle cycle between bursts.
REQ-034 Only FIFO 2 is non-empty after reset -> gnt=2 and ptr becomes 3; a following FIFO 1 request is granted next, ahead of any re-grant of 2.
REQ-035 FIFO 0 holds 5 words at grant, then 3 more words arrive 10 cycles later -> out_valid drops after word 5, no other requester is granted, and the burst completes with out_last on word 8.
REQ-036 out_ready toggles 1,0,1,0 during a burst -> no fifo_rd_en on ready=0 cycles, out_data stable, and exactly 8 pops total.
REQ-037 en deasserted at word 3 of a burst -> the burst finishes all 8 words, and no new grant occurs until en=1.
REQ-038 rst pulsed at word 4 of a requester-2 burst -> the next cycle has busy=0 and fifo_rd_en=0, and the next grant searches from requester 0.

Source files
------------

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NREQ first-word-fall-through FIFOs into a single
// valid/ready stream. Each grant moves exactly BURST words from one FIFO
// before another requester can be considered.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant held; picks the next non-empty FIFO from ptr when en=1
// XFER  | draining the granted FIFO until BURST words have been accepted
module fifo_rr_drain #(
    parameter int NREQ  = 4,
    parameter int BURST = 8
) (
    input  logic                      rd_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NREQ-1:0]           fifo_empty,
    input  logic [NREQ*32-1:0]        fifo_dout,
    output logic [NREQ-1:0]           fifo_rd_en,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NREQ)-1:0]   out_src,
    output logic                      out_last,
    output logic                      busy
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(BURST);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    logic [SW-1:0]   gnt;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   nxt_gnt;
    logic [SW-1:0]   idx_s;
    logic [CW-1:0]   cnt;
    logic            any_req;
    logic            in_xfer;
    logic            xfer_word;
    int              idx;

    // Round-robin search: walk from ptr+NREQ-1 down to ptr so the lowest
    // offset from ptr that is non-empty is the one left standing.
    always_comb begin
        any_req = |(~fifo_empty);
        nxt_gnt = ptr;
        idx     = 0;
        idx_s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx   = (int'(ptr) + k) % NREQ;
            idx_s = SW'(idx);
            if (!fifo_empty[idx_s]) begin
                nxt_gnt = idx_s;
            end
        end
    end

    // Datapath mux and handshake. Gated by rst so nothing pops or shows
    // valid on the reset cycle itself, even if the FSM was mid-burst.
    always_comb begin
        in_xfer    = (state == XFER) && !rst;
        busy       = in_xfer;
        out_valid  = in_xfer && !fifo_empty[gnt];
        out_data   = fifo_dout[gnt*32 +: 32];
        out_src    = gnt;
        out_last   = out_valid && (cnt == CW'(BURST - 1));
        xfer_word  = out_valid && out_ready;
        fifo_rd_en = '0;
        if (xfer_word) begin
            fifo_rd_en[gnt] = 1'b1;
        end
    end

    // Grant/burst FSM. A burst only ends after BURST accepted words; an
    // empty granted FIFO simply stalls it, and en is only looked at in IDLE.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && any_req) begin
                        gnt   <= nxt_gnt;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_word) begin
                        if (cnt == CW'(BURST - 1)) begin
                            cnt   <= '0;
                            ptr   <= (gnt == SW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
